// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY0 = 2'd1,
    ARB_BUSY1 = 2'd2
  } arb_state_e;

  // Read data handed back to a master whose transaction timed out.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_if.sv
// picorv32-native memory bus (valid/ready/addr/wdata/wstrb/rdata).
// A bus master drives the request side; a slave answers with ready/rdata.
interface mem_arbiter_if;

  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
  modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/mem_arbiter.sv
// Non-preemptive round-robin arbiter sharing one native memory port between
// two masters, with a per-transaction timeout that forces completion.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_arbiter_if.slave         m0,
  mem_arbiter_if.slave         m1,
  mem_arbiter_if.master        s,
  output logic [1:0]           grant,
  output logic                 timeout
);

  localparam int unsigned    CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMO_MAX = CW'(TIMEOUT);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q;

  logic busy;
  logic tmo_fire;
  logic done;

  assign busy     = (state_q != ARB_IDLE);
  // s_ready in the limit cycle takes priority: real data, no timeout pulse.
  assign tmo_fire = busy && !s.ready && (cnt_q == TMO_MAX);
  assign done     = busy && (s.ready || tmo_fire);

  // Next-state and round-robin selection; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (m0.valid && m1.valid) begin
          if (last_q) begin
            state_d = ARB_BUSY0;
            last_d  = 1'b0;
          end else begin
            state_d = ARB_BUSY1;
            last_d  = 1'b1;
          end
        end else if (m0.valid) begin
          state_d = ARB_BUSY0;
          last_d  = 1'b0;
        end else if (m1.valid) begin
          state_d = ARB_BUSY1;
          last_d  = 1'b1;
        end
      end
      ARB_BUSY0, ARB_BUSY1: begin
        if (done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM state and last-granted master; last resets to 1 so m0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Timeout counter: zero while idle, so it is clear on BUSY entry; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else if (!s.ready && (cnt_q != TMO_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Port mux: everything derives from the state and the slave response only.
  always_comb begin
    s.valid  = 1'b0;
    s.addr   = '0;
    s.wdata  = '0;
    s.wstrb  = '0;
    m0.ready = 1'b0;
    m0.rdata = '0;
    m1.ready = 1'b0;
    m1.rdata = '0;
    timeout  = tmo_fire;
    grant    = {state_q == ARB_BUSY1, state_q == ARB_BUSY0};
    unique case (state_q)
      ARB_BUSY0: begin
        s.valid  = 1'b1;
        s.addr   = m0.addr;
        s.wdata  = m0.wdata;
        s.wstrb  = m0.wstrb;
        m0.ready = s.ready || tmo_fire;
        m0.rdata = tmo_fire ? ERR_DATA : s.rdata;
      end
      ARB_BUSY1: begin
        s.valid  = 1'b1;
        s.addr   = m1.addr;
        s.wdata  = m1.wdata;
        s.wstrb  = m1.wstrb;
        m1.ready = s.ready || tmo_fire;
        m1.rdata = tmo_fire ? ERR_DATA : s.rdata;
      end
      default: ;
    endcase
  end

  // A granted master must hold its request until it sees ready.
  a_m0_hold: assert property (@(posedge clk) disable iff (!rst_n)
                              (state_q == ARB_BUSY0) |-> m0.valid);
  a_m1_hold: assert property (@(posedge clk) disable iff (!rst_n)
                              (state_q == ARB_BUSY1) |-> m1.valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and checks whenever a master ready appears.
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant;
  logic       timeout;

  mem_arbiter_if m0_if ();
  mem_arbiter_if m1_if ();
  mem_arbiter_if s_if ();

  mem_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .grant   (grant),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push(int id, logic [31:0] rdata, logic tmo);
    exp_t e;
    e.id    = id;
    e.rdata = rdata;
    e.tmo   = tmo;
    sb.push_back(e);
  endfunction

  // Monitor: every ready/timeout observed must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (m0_if.ready || m1_if.ready || timeout)) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ready: got ready=%b%b timeout=%b expected none",
                   m1_if.ready, m0_if.ready, timeout);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ready_id", {30'd0, m1_if.ready, m0_if.ready}, (e.id == 1) ? 32'd2 : 32'd1);
          chk("rdata", (e.id == 1) ? m1_if.rdata : m0_if.rdata, e.rdata);
          chk("other_rdata", (e.id == 1) ? m0_if.rdata : m1_if.rdata, 32'd0);
          chk("timeout", {31'd0, timeout}, {31'd0, e.tmo});
          chk("grant_at_ready", {30'd0, grant}, (e.id == 1) ? 32'd2 : 32'd1);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(int id, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb);
    if (id == 0) begin
      m0_if.valid = 1'b1; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.wstrb = wstrb;
    end else begin
      m1_if.valid = 1'b1; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.wstrb = wstrb;
    end
  endtask

  task automatic drop_req(int id);
    if (id == 0) begin
      m0_if.valid = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.wstrb = '0;
    end else begin
      m1_if.valid = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.wstrb = '0;
    end
  endtask

  // One transaction from a single master; the slave answers after wait_cyc
  // extra BUSY cycles, or never (answer=0) so the timeout must complete it.
  task automatic single(int id, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                        int wait_cyc, bit answer, logic [31:0] rdata);
    cyc();
    drive_req(id, addr, wdata, wstrb);
    push(id, answer ? rdata : 32'hDEAD_BEEF, !answer);
    cyc();
    chk("grant_busy", {30'd0, grant}, (id == 1) ? 32'd2 : 32'd1);
    chk("s_valid_busy", {31'd0, s_if.valid}, 32'd1);
    chk("s_addr", s_if.addr, addr);
    chk("s_wdata", s_if.wdata, wdata);
    chk("s_wstrb", {28'd0, s_if.wstrb}, {28'd0, wstrb});
    repeat (wait_cyc) cyc();
    if (answer) begin
      s_if.ready = 1'b1;
      s_if.rdata = rdata;
    end
    cyc();
    s_if.ready = 1'b0;
    s_if.rdata = '0;
    drop_req(id);
    chk("grant_idle_after", {30'd0, grant}, 32'd0);
    chk("s_valid_idle_after", {31'd0, s_if.valid}, 32'd0);
  endtask

  // Both masters request together; 'first' is the master expected to win.
  task automatic contend(int first, logic [31:0] r_first, logic [31:0] r_second);
    int second;
    second = 1 - first;
    cyc();
    drive_req(0, 32'h0000_3000, 32'h0, 4'h0);
    drive_req(1, 32'h0000_4000, 32'h0, 4'h0);
    push(first, r_first, 1'b0);
    push(second, r_second, 1'b0);
    cyc();
    chk("contend_grant_first", {30'd0, grant}, (first == 1) ? 32'd2 : 32'd1);
    s_if.ready = 1'b1;
    s_if.rdata = r_first;
    cyc();
    s_if.ready = 1'b0;
    s_if.rdata = '0;
    drop_req(first);
    chk("contend_gap_grant", {30'd0, grant}, 32'd0);
    chk("contend_gap_s_valid", {31'd0, s_if.valid}, 32'd0);
    cyc();
    chk("contend_grant_second", {30'd0, grant}, (second == 1) ? 32'd2 : 32'd1);
    s_if.ready = 1'b1;
    s_if.rdata = r_second;
    cyc();
    s_if.ready = 1'b0;
    s_if.rdata = '0;
    drop_req(second);
    chk("contend_end_grant", {30'd0, grant}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drop_req(0);
    drop_req(1);
    s_if.ready = 1'b0;
    s_if.rdata = '0;
    #2;
    chk("rst_s_valid", {31'd0, s_if.valid}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ready", {30'd0, m1_if.ready, m0_if.ready}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_rdata", m0_if.rdata | m1_if.rdata, 32'd0);
    chk("rst_s_bus", s_if.addr | s_if.wdata | {28'd0, s_if.wstrb}, 32'd0);
    cyc();
    rst_n = 1'b1;

    // Contention straight after reset: m0 first, m1 after one idle cycle.
    contend(0, 32'h1111_0000, 32'h2222_0000);
    // Single m0 read, slave answers on the 4th BUSY cycle.
    single(0, 32'h0001_0000, 32'h0, 4'h0, 3, 1'b1, 32'h1234_5678);
    // m0 was last granted, so contention now favours m1.
    contend(1, 32'h3333_0000, 32'h4444_0000);
    // m1 write forwarding.
    single(1, 32'h0002_0004, 32'hA5A5_A5A5, 4'b0011, 1, 1'b1, 32'h0);
    // Timeout: slave never answers, completes on the 5th BUSY cycle.
    single(0, 32'h0000_0100, 32'h0, 4'h0, 4, 1'b0, 32'h0);
    // Next request after a timeout is served normally.
    single(0, 32'h0000_0104, 32'h0, 4'h0, 0, 1'b1, 32'hCAFE_F00D);
    // s_ready exactly in the timeout cycle: real data, no timeout pulse.
    single(1, 32'h0000_0200, 32'h0, 4'h0, 4, 1'b1, 32'h5A5A_0001);

    // Asynchronous reset during BUSY1: no ready to anyone.
    cyc();
    drive_req(1, 32'h0000_0300, 32'h0, 4'h0);
    cyc();
    chk("pre_reset_grant", {30'd0, grant}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s_valid", {31'd0, s_if.valid}, 32'd0);
    chk("async_rst_grant", {30'd0, grant}, 32'd0);
    chk("async_rst_ready", {30'd0, m1_if.ready, m0_if.ready}, 32'd0);
    drop_req(1);
    cyc();
    rst_n = 1'b1;
    // last was restored to 1 by reset, so m0 wins again.
    contend(0, 32'h7777_0000, 32'h8888_0000);

    repeat (3) cyc();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
